// File: rtl/mmio_timer_gpio_if.sv
// Bus-side control signals of the mmio_timer_gpio responder.
//   CS   : pre-decoded chip select (driven by the top-level decoder)
//   WE   : write enable, meaningful only while CS=1
//   ADDR : register index, ADDR[2:0] of the CPU address
// The shared 32-bit Mem_Bus stays a plain inout on the responder.
interface mmio_timer_gpio_if;
  logic       CS;
  logic       WE;
  logic [2:0] ADDR;

  modport master (output CS, output WE, output ADDR);
  modport slave  (input  CS, input  WE, input  ADDR);
endinterface

// File: rtl/mmio_timer_gpio.sv
// Memory-mapped ID / switch / LED / timer responder on the CPU memory bus.
// Same timing as Memory: read data is registered one CLK after CS/ADDR settle.
//   CLK     : system clock
//   RST     : synchronous, active-high reset
//   bus     : CS / WE / ADDR (slave modport)
//   Mem_Bus : shared data bus, driven only while CS=1 and WE=0
//   sw      : asynchronous switch inputs (2-flop synchronised)
//   led     : LED register
//   irq     : timer interrupt, MATCH & IRQEN
// Register map: 0 ID, 1 SW, 2 LED, 3 CNT, 4 CMP, 5 CTRL{IRQEN,AUTORELOAD,EN},
// 6 STATUS{MATCH, W1C}, 7 reserved.
module mmio_timer_gpio #(
  parameter logic [31:0] ID_VALUE = 32'h4D494F31,
  parameter int unsigned PRESCALE = 10
) (
  input  logic                CLK,
  input  logic                RST,
  mmio_timer_gpio_if.slave    bus,
  inout  wire  [31:0]         Mem_Bus,
  input  logic [2:0]          sw,
  output logic [7:0]          led,
  output logic                irq
);

  localparam logic [15:0] PrescLast = 16'(PRESCALE - 1);

  logic [7:0]  led_q, led_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  sw_meta_q, sw_sync_q;
  logic        irq_q, irq_d;

  logic        wr_en, rd_en, tick, match_set, match_clr;
  logic [31:0] wdata, rd_val;

  assign wr_en = bus.CS & bus.WE;
  assign rd_en = bus.CS & ~bus.WE;
  assign wdata = Mem_Bus;

  assign Mem_Bus = rd_en ? rdata_q : 'z;
  assign led     = led_q;
  assign irq     = irq_q;

  always_comb begin
    rd_val = '0;
    case (bus.ADDR)
      3'd0:    rd_val = ID_VALUE;
      3'd1:    rd_val = {29'b0, sw_sync_q};
      3'd2:    rd_val = {24'b0, led_q};
      3'd3:    rd_val = cnt_q;
      3'd4:    rd_val = cmp_q;
      3'd5:    rd_val = {29'b0, ctrl_q};
      3'd6:    rd_val = {31'b0, match_q};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    led_d     = led_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    match_set = 1'b0;
    match_clr = 1'b0;
    rdata_d   = rd_en ? rd_val : rdata_q;

    tick    = ctrl_q[0] && (presc_q == PrescLast);
    presc_d = (ctrl_q[0] && !tick) ? presc_q + 16'd1 : 16'd0;

    // Match is judged on the pre-edge count, even if a bus write replaces it.
    if (tick) begin
      if (cnt_q == cmp_q) begin
        match_set = 1'b1;
        cnt_d     = ctrl_q[1] ? 32'd0 : cnt_q + 32'd1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    if (wr_en) begin
      case (bus.ADDR)
        3'd2: led_d = wdata[7:0];
        3'd3: cnt_d = wdata;
        3'd4: cmp_d = wdata;
        3'd5: begin
          ctrl_d = wdata[2:0];
          if (!wdata[0]) presc_d = 16'd0;
        end
        3'd6:    match_clr = wdata[0];
        default: ;
      endcase
    end

    // A new match outranks a simultaneous write-1-to-clear.
    match_d = match_set | (match_q & ~match_clr);
    irq_d   = match_d & ctrl_d[2];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q     <= '0;
      cnt_q     <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      ctrl_q    <= '0;
      match_q   <= 1'b0;
      presc_q   <= '0;
      rdata_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
      presc_q   <= presc_d;
      rdata_q   <= rdata_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Self-checking bench for mmio_timer_gpio: directed scenarios followed by
// random bus traffic, all judged against a cycle-level behavioural model.
module tb_mmio_timer_gpio;

  localparam int unsigned Prescale = 10;
  localparam logic [31:0] IdValue  = 32'h4D494F31;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sw;
  logic [7:0]  led;
  logic        irq;
  wire  [31:0] mem_bus;
  logic        drv_oe;
  logic [31:0] drv_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Behavioural model state
  logic [7:0]  m_led;
  logic [31:0] m_cnt, m_cmp, m_rdata;
  logic [2:0]  m_ctrl, m_meta, m_sync;
  logic        m_match;
  int unsigned m_age;  // edges elapsed since the timer was enabled

  assign mem_bus = drv_oe ? drv_data : 'z;

  mmio_timer_gpio_if bus ();

  mmio_timer_gpio #(
    .ID_VALUE(IdValue),
    .PRESCALE(Prescale)
  ) u_dut (
    .CLK    (clk),
    .RST    (rst),
    .bus    (bus),
    .Mem_Bus(mem_bus),
    .sw     (sw),
    .led    (led),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return IdValue;
      3'd1:    return {29'b0, m_sync};
      3'd2:    return {24'b0, m_led};
      3'd3:    return m_cnt;
      3'd4:    return m_cmp;
      3'd5:    return {29'b0, m_ctrl};
      3'd6:    return {31'b0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_ctrl = '0; m_match = 1'b0;
    m_rdata = '0; m_meta = '0; m_sync = '0; m_age = 0;
  endtask

  task automatic model_edge(input logic cs, input logic we, input logic [2:0] addr,
                            input logic [31:0] wdata);
    logic        tick, set;
    logic [31:0] next_cnt;
    tick = m_ctrl[0] && ((m_age % Prescale) == Prescale - 1);
    set  = 1'b0;
    if (cs && !we) m_rdata = model_read(addr);
    next_cnt = m_cnt;
    if (tick) begin
      if (m_cnt == m_cmp) begin
        set      = 1'b1;
        next_cnt = m_ctrl[1] ? 32'd0 : m_cnt + 32'd1;
      end else begin
        next_cnt = m_cnt + 32'd1;
      end
    end
    m_age  = m_ctrl[0] ? m_age + 1 : 0;
    m_sync = m_meta;
    m_meta = sw;
    m_cnt  = next_cnt;
    if (cs && we) begin
      case (addr)
        3'd2: m_led = wdata[7:0];
        3'd3: m_cnt = wdata;
        3'd4: m_cmp = wdata;
        3'd5: begin
          m_ctrl = wdata[2:0];
          if (!wdata[0]) m_age = 0;
        end
        3'd6:    if (wdata[0]) m_match = 1'b0;
        default: ;
      endcase
    end
    if (set) m_match = 1'b1;
  endtask

  task automatic check_outputs(input logic cs, input logic we);
    check_value("led", {24'b0, led}, {24'b0, m_led});
    check_value("irq", {31'b0, irq}, {31'b0, m_match & m_ctrl[2]});
    if (cs && !we) check_value("rdata", mem_bus, m_rdata);
    else           check_value("bus_free", mem_bus, drv_data);
  endtask

  task automatic cycle(input logic cs, input logic we, input logic [2:0] addr,
                       input logic [31:0] wdata);
    bus.CS   = cs;
    bus.WE   = we;
    bus.ADDR = addr;
    drv_oe   = we || !cs;
    drv_data = (cs && we) ? wdata : $urandom();
    @(posedge clk);
    model_edge(cs, we, addr, wdata);
    #1;
    check_outputs(cs, we);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd_chk(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    cycle(1'b1, 1'b0, addr, 32'd0);
    check_value(tag, mem_bus, exp);
  endtask

  // Optionally holds a read on the bus during reset: the bus must then carry 0.
  task automatic reset_cycles(input int n, input logic rd);
    rst      = 1'b1;
    bus.CS   = rd;
    bus.WE   = 1'b0;
    bus.ADDR = 3'd3;
    drv_oe   = !rd;
    drv_data = $urandom();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_reset();
      #1;
      check_value("rst_led", {24'b0, led}, 32'd0);
      check_value("rst_irq", {31'b0, irq}, 32'd0);
      if (rd) check_value("rst_bus", mem_bus, 32'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0]  a;
    logic [31:0] d;
    int unsigned r;
    sw = 3'd0;
    model_reset();

    // Reset and ID
    reset_cycles(2, 1'b0);
    rd_chk(3'd0, IdValue, "id");
    rd_chk(3'd3, 32'd0, "cnt_rst");
    rd_chk(3'd4, 32'hFFFF_FFFF, "cmp_rst");
    rd_chk(3'd5, 32'd0, "ctrl_rst");
    rd_chk(3'd6, 32'd0, "status_rst");

    // LED and switches
    cycle(1'b1, 1'b1, 3'd2, 32'h1234_56A5);
    check_value("led_a5", {24'b0, led}, 32'h0000_00A5);
    rd_chk(3'd2, 32'h0000_00A5, "led_rd");
    sw = 3'b101;
    rd_chk(3'd1, 32'd0, "sw_edge1");
    rd_chk(3'd1, 32'd0, "sw_edge2");
    rd_chk(3'd1, 32'd5, "sw_edge3");
    cycle(1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF);
    rd_chk(3'd0, IdValue, "id_ro");

    // Free-running timer, CMP=3
    reset_cycles(1, 1'b0);
    cycle(1'b1, 1'b1, 3'd4, 32'd3);
    cycle(1'b1, 1'b1, 3'd5, 32'd1);
    idle(30);
    rd_chk(3'd6, 32'd0, "match_c31");
    idle(9);
    rd_chk(3'd6, 32'd1, "match_c41");
    rd_chk(3'd3, 32'd4, "cnt_c42");
    check_value("irq_noen", {31'b0, irq}, 32'd0);

    // Autoreload and interrupt, CMP=2
    reset_cycles(1, 1'b0);
    cycle(1'b1, 1'b1, 3'd4, 32'd2);
    cycle(1'b1, 1'b1, 3'd5, 32'd7);
    idle(10); rd_chk(3'd3, 32'd1, "ar_t1");
    idle(9);  rd_chk(3'd3, 32'd2, "ar_t2");
    check_value("irq_t2", {31'b0, irq}, 32'd0);
    idle(9);  rd_chk(3'd3, 32'd0, "ar_t3");
    check_value("irq_t3", {31'b0, irq}, 32'd1);
    cycle(1'b1, 1'b1, 3'd6, 32'd1);
    check_value("irq_w1c", {31'b0, irq}, 32'd0);
    idle(8);  rd_chk(3'd3, 32'd1, "ar_t4");
    idle(9);  rd_chk(3'd3, 32'd2, "ar_t5");
    check_value("irq_t5", {31'b0, irq}, 32'd0);
    idle(9);  rd_chk(3'd3, 32'd0, "ar_t6");
    check_value("irq_t6", {31'b0, irq}, 32'd1);

    // CNT write on a tick edge
    reset_cycles(1, 1'b0);
    cycle(1'b1, 1'b1, 3'd4, 32'hFFFF_0000);
    cycle(1'b1, 1'b1, 3'd5, 32'd1);
    idle(9);
    cycle(1'b1, 1'b1, 3'd3, 32'd100);
    rd_chk(3'd3, 32'd100, "cnt_wr_tick");

    // W1C on a match edge
    reset_cycles(1, 1'b0);
    cycle(1'b1, 1'b1, 3'd4, 32'd1);
    cycle(1'b1, 1'b1, 3'd5, 32'd1);
    idle(19);
    cycle(1'b1, 1'b1, 3'd6, 32'd1);
    rd_chk(3'd6, 32'd1, "w1c_vs_set");

    // Wrap without a flag
    reset_cycles(1, 1'b0);
    cycle(1'b1, 1'b1, 3'd3, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 3'd4, 32'd0);
    cycle(1'b1, 1'b1, 3'd5, 32'd1);
    idle(10);
    rd_chk(3'd3, 32'd0, "wrap_cnt");
    rd_chk(3'd6, 32'd0, "wrap_nomatch");

    // Reset in the middle of operation, with a read on the bus
    reset_cycles(1, 1'b0);
    cycle(1'b1, 1'b1, 3'd2, 32'hFF);
    cycle(1'b1, 1'b1, 3'd4, 32'd6);
    cycle(1'b1, 1'b1, 3'd3, 32'd6);
    cycle(1'b1, 1'b1, 3'd5, 32'd5);
    idle(10);
    check_value("pre_rst_irq", {31'b0, irq}, 32'd1);
    rd_chk(3'd3, 32'd7, "pre_rst_cnt");
    reset_cycles(1, 1'b1);
    idle(25);
    rd_chk(3'd3, 32'd0, "post_rst_cnt");
    rd_chk(3'd6, 32'd0, "post_rst_status");
    rd_chk(3'd5, 32'd0, "post_rst_ctrl");
    rd_chk(3'd4, 32'hFFFF_FFFF, "post_rst_cmp");
    rd_chk(3'd2, 32'd0, "post_rst_led");

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(9) == 0) sw = 3'($urandom());
      r = $urandom_range(499);
      a = 3'($urandom());
      if (r == 0) begin
        reset_cycles(1, 1'($urandom()));
      end else if (r < 150) begin
        cycle(1'b0, 1'($urandom()), a, 32'd0);
      end else if (r < 325) begin
        cycle(1'b1, 1'b0, a, 32'd0);
      end else begin
        d = $urandom();
        if ((a == 3'd3 || a == 3'd4) && $urandom_range(7) != 0) d = $urandom_range(30);
        if (a == 3'd5) d[0] = ($urandom_range(3) != 0);
        cycle(1'b1, 1'b1, a, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
